// File: rtl/nec_div_pkg.sv
// nec_div_pkg: shared types and constants for the DIV/DIVU sequencer.
//   div_state_t      - sequencer FSM states
//   DIV_LATENCY      - ce cycles from req sample to done (normal path)
//   DIV_DBZ_LATENCY  - ce cycles from req sample to done (zero divisor)
//   build_dividend / build_divisor - 33-bit operand construction
package nec_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } div_state_t;

    localparam int DIV_LATENCY     = 35;
    localparam int DIV_DBZ_LATENCY = 3;

    // Word: DW:AW with a sign bit on top. Byte: AW extended to 33 bits.
    function automatic logic [32:0] build_dividend(input logic s, input logic w,
                                                   input logic [31:0] d);
        if (w)
            return {s & d[31], d};
        return {{17{s & d[15]}}, d[15:0]};
    endfunction

    // Word: r16 extended to 33 bits. Byte: r8 extended to 33 bits.
    function automatic logic [32:0] build_divisor(input logic s, input logic w,
                                                  input logic [15:0] d);
        if (w)
            return {{17{s & d[15]}}, d};
        return {{25{s & d[7]}}, d[7:0]};
    endfunction

endpackage

// File: rtl/nec_divider.sv
// nec_divider: 32-step restoring divider on operand magnitudes.
//   clk, reset, ce  - clock, async active-high reset, clock enable
//   start           - one ce cycle: load operands, clear done
//   wide            - 1: quotient must fit 16 bits, 0: 8 bits (overflow flag)
//   a, b            - 33-bit two's complement dividend / divisor
//   done            - level, set when result valid (immediately for b == 0)
//   dbz             - divisor was zero
//   ovf             - quotient magnitude exceeds the mode width
//   quot, rem       - signed quotient (truncated) and remainder (dividend sign)
module nec_divider
    import nec_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic        wide,
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic        done,
    output logic        dbz,
    output logic        ovf,
    output logic [15:0] quot,
    output logic [15:0] rem
);

    logic [32:0] a_abs;
    logic [32:0] b_abs;
    logic        b_zero;
    logic [31:0] q_sh;     // dividend bits shift out the top, quotient bits in at the bottom
    logic [16:0] r_acc;    // partial remainder, always < b_mag
    logic [16:0] b_mag;
    logic [17:0] trial;
    logic [4:0]  step;
    logic        run;
    logic        neg_q;
    logic        neg_r;

    assign a_abs  = a[32] ? (~a + 33'd1) : a;
    assign b_abs  = b[32] ? (~b + 33'd1) : b;
    assign b_zero = (b_abs == 33'd0);
    assign trial  = {r_acc, q_sh[31]} - {1'b0, b_mag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_sh  <= '0;
            r_acc <= '0;
            b_mag <= '0;
            step  <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (ce) begin
            if (start) begin
                q_sh  <= a_abs[31:0];
                // a_abs[32] is never set for legal operands; seeding it keeps the math exact.
                r_acc <= {16'd0, a_abs[32]};
                b_mag <= b_abs[16:0];
                neg_q <= a[32] ^ b[32];
                neg_r <= a[32];
                step  <= '0;
                run   <= !b_zero;
                done  <= b_zero;
                dbz   <= b_zero;
            end else if (run) begin
                if (!trial[17]) begin
                    r_acc <= trial[16:0];
                    q_sh  <= {q_sh[30:0], 1'b1};
                end else begin
                    r_acc <= {r_acc[15:0], q_sh[31]};
                    q_sh  <= {q_sh[30:0], 1'b0};
                end
                step <= step + 5'd1;
                if (step == 5'd31) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign ovf  = wide ? (|q_sh[31:16]) : (|q_sh[31:8]);
    assign quot = neg_q ? (~q_sh[15:0] + 16'd1) : q_sh[15:0];
    assign rem  = neg_r ? (~r_acc[15:0] + 16'd1) : r_acc[15:0];

endmodule

// File: rtl/nec_div_ctrl.sv
// nec_div_ctrl: DIV/DIVU sequencer around nec_divider.
//   clk, reset, ce      - clock, async active-high reset, clock enable
//   req                 - start request (sampled in IDLE only)
//   is_signed, wide     - DIV vs DIVU, 32/16 vs 16/8; captured with req
//   dividend, divisor   - operands; captured with req
//   busy                - high from cycle after acceptance through done cycle
//   done                - one-ce-cycle result pulse
//   err, err_dbz        - divide error / zero-divisor cause, valid with done
//   quot, rem           - registered results (byte mode zero-fills [15:8])
//   dbg_state           - current FSM state (div_state_t encoding)
//
// Handshake: req is accepted only on a ce edge while busy is low; every
// acceptance produces exactly one done pulse, and req seen while busy is
// ignored (a held req is re-accepted the first idle cycle after done).
module nec_div_ctrl
    import nec_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        req,
    input  logic        is_signed,
    input  logic        wide,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        err_dbz,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic [1:0]  dbg_state
);

    div_state_t  state_q, state_d;
    logic        capture;
    logic        load;
    logic        div_start;
    logic [32:0] a_q, b_q;
    logic        wide_q, signed_q;
    logic        div_done, div_dbz, div_ovf;
    logic [15:0] div_quot, div_rem;
    logic        neg, q_sign, q_nz, range_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else if (ce)
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        load      = 1'b0;
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
        div_start = (state_q == LAUNCH);
        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (div_done) begin
                    load    = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            wide_q   <= 1'b0;
            signed_q <= 1'b0;
        end else if (ce && capture) begin
            a_q      <= build_dividend(is_signed, wide, dividend);
            b_q      <= build_divisor(is_signed, wide, divisor);
            wide_q   <= wide;
            signed_q <= is_signed;
        end
    end

    nec_divider u_divider (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (div_start),
        .wide  (wide_q),
        .a     (a_q),
        .b     (b_q),
        .done  (div_done),
        .dbz   (div_dbz),
        .ovf   (div_ovf),
        .quot  (div_quot),
        .rem   (div_rem)
    );

    // The divider only flags magnitude overflow; a magnitude that fits the
    // unsigned width can still fall outside the signed range.
    assign neg       = a_q[32] ^ b_q[32];
    assign q_sign    = wide_q ? div_quot[15] : div_quot[7];
    assign q_nz      = wide_q ? (|div_quot) : (|div_quot[7:0]);
    assign range_err = signed_q && ((!neg && q_sign) || (neg && !q_sign && q_nz));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err     <= 1'b0;
            err_dbz <= 1'b0;
            quot    <= '0;
            rem     <= '0;
        end else if (ce && load) begin
            if (div_dbz) begin
                err     <= 1'b1;
                err_dbz <= 1'b1;
            end else if (div_ovf || range_err) begin
                err     <= 1'b1;
                err_dbz <= 1'b0;
            end else begin
                err     <= 1'b0;
                err_dbz <= 1'b0;
                quot    <= wide_q ? div_quot : {8'h00, div_quot[7:0]};
                rem     <= wide_q ? div_rem  : {8'h00, div_rem[7:0]};
            end
        end
    end

endmodule

// File: tb/tb_nec_div_ctrl.sv
module tb_nec_div_ctrl;
    import nec_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        req;
    logic        is_signed;
    logic        wide;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy, done, err, err_dbz;
    logic [15:0] quot, rem;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state: results hold across errors.
    logic [15:0] m_quot = 16'h0;
    logic [15:0] m_rem  = 16'h0;

    nec_div_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .req       (req),
        .is_signed (is_signed),
        .wide      (wide),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_dbz   (err_dbz),
        .quot      (quot),
        .rem       (rem),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Integer-arithmetic model of the divide instruction.
    task automatic model(input logic s, input logic w, input logic [31:0] dvd,
                         input logic [15:0] dvs, output logic e, output logic ed);
        longint a_v, b_v, q_v, r_v, lo, hi;
        if (w) begin
            a_v = s ? longint'($signed(dvd)) : longint'(dvd);
            b_v = s ? longint'($signed(dvs)) : longint'(dvs);
            lo  = s ? -32768 : 0;
            hi  = s ? 32767 : 65535;
        end else begin
            a_v = s ? longint'($signed(dvd[15:0])) : longint'(dvd[15:0]);
            b_v = s ? longint'($signed(dvs[7:0])) : longint'(dvs[7:0]);
            lo  = s ? -128 : 0;
            hi  = s ? 127 : 255;
        end
        if (b_v == 0) begin
            e  = 1'b1;
            ed = 1'b1;
        end else begin
            q_v = a_v / b_v;
            r_v = a_v % b_v;
            ed  = 1'b0;
            if (q_v < lo || q_v > hi) begin
                e = 1'b1;
            end else begin
                e = 1'b0;
                m_quot = w ? q_v[15:0] : {8'h00, q_v[7:0]};
                m_rem  = w ? r_v[15:0] : {8'h00, r_v[7:0]};
            end
        end
    endtask

    // One full operation: request, wait for done (counting ce cycles), check, return to idle.
    task automatic run_op(input logic s, input logic w, input logic [31:0] dvd,
                          input logic [15:0] dvs, input bit tog);
        int   cyc;
        int   budget;
        bit   cur_ce;
        bit   seen;
        bit   left;
        logic e_exp, ed_exp;
        int   lat_exp;

        model(s, w, dvd, dvs, e_exp, ed_exp);
        lat_exp = ed_exp ? DIV_DBZ_LATENCY : DIV_LATENCY;

        is_signed = s;
        wide      = w;
        dividend  = dvd;
        divisor   = dvs;
        req       = 1'b1;
        budget    = 0;
        do begin
            cur_ce = ce;
            @(posedge clk);
            #1;
            if (tog) ce = 1'($urandom_range(0, 1));
            budget++;
        end while (!cur_ce && budget < 100);
        req = 1'b0;
        chk("busy_after_accept", busy, 1'b1);

        cyc  = 1;
        seen = 0;
        while (!seen && budget < 400) begin
            if (done) begin
                seen = 1;
            end else begin
                cur_ce = ce;
                @(posedge clk);
                #1;
                if (tog) ce = 1'($urandom_range(0, 1));
                if (cur_ce) cyc++;
                budget++;
            end
        end
        chk("done_seen", seen, 1'b1);
        chk("latency", cyc, lat_exp);
        chk("busy_at_done", busy, 1'b1);
        chk("err", err, e_exp);
        chk("err_dbz", err_dbz, ed_exp);
        chk("quot", quot, m_quot);
        chk("rem", rem, m_rem);

        // Done must hold through ce-low cycles and drop after one ce cycle.
        left = 0;
        while (!left && budget < 500) begin
            cur_ce = ce;
            @(posedge clk);
            #1;
            if (tog) ce = 1'($urandom_range(0, 1));
            budget++;
            if (cur_ce) left = 1;
            else chk("done_hold_ce_low", done, 1'b1);
        end
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        ce = 1'b1;
    endtask

    initial begin
        logic [31:0] r32;
        logic [15:0] r16;
        logic        rs, rw;
        int          k, dones, cyc;

        reset = 1'b1;
        ce = 1'b1;
        req = 1'b0;
        is_signed = 1'b0;
        wide = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_dbz", err_dbz, 1'b0);
        chk("rst_quot", quot, 16'h0);
        chk("rst_rem", rem, 16'h0);
        chk("rst_state", dbg_state, 2'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        run_op(1'b0, 1'b1, 32'h0001_0000, 16'h0003, 1'b0);
        chk("plan_divu_word_quot", quot, 16'h5555);
        chk("plan_divu_word_rem", rem, 16'h0001);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 16'h0002, 1'b0);
        chk("plan_div_word_quot", quot, 16'hFFFD);
        chk("plan_div_word_rem", rem, 16'hFFFF);
        run_op(1'b0, 1'b0, 32'h0000_0100, 16'h0002, 1'b0);
        chk("plan_divu_byte_quot", quot, 16'h0080);
        run_op(1'b0, 1'b0, 32'h0000_0200, 16'h0002, 1'b0);
        chk("plan_byte_ovf_err", err, 1'b1);
        chk("plan_byte_ovf_hold", quot, 16'h0080);
        run_op(1'b1, 1'b1, 32'h0000_8000, 16'h0001, 1'b0);
        chk("plan_word_pos_range_err", err, 1'b1);
        run_op(1'b1, 1'b1, 32'hFFFF_8000, 16'h0001, 1'b0);
        chk("plan_word_neg_min_quot", quot, 16'h8000);
        run_op(1'b1, 1'b0, 32'h0000_0080, 16'h0001, 1'b0);
        chk("plan_byte_pos_range_err", err, 1'b1);
        run_op(1'b1, 1'b1, 32'hFFFF_6FFF, 16'h0001, 1'b0);
        run_op(1'b0, 1'b1, 32'h0000_1234, 16'h0000, 1'b0);
        run_op(1'b1, 1'b0, 32'h0000_0055, 16'hFF00, 1'b0);
        run_op(1'b0, 1'b1, 32'h0001_0000, 16'h0003, 1'b1);

        // Randomized operations, half of them with ce toggling.
        for (int i = 0; i < 24; i++) begin
            k   = $urandom_range(0, 3);
            rs  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            r32 = $urandom;
            r16 = 16'($urandom);
            case (k)
                0: ;
                1: r32 = {{16{r32[15]}}, r32[15:0]};
                2: r16 = 16'h0000;
                default: begin
                    r32 = 32'($urandom_range(0, 1000));
                    r16 = 16'($urandom_range(1, 50));
                end
            endcase
            run_op(rs, rw, r32, r16, bit'(i[0]));
        end

        // Reset in WAIT cycle 10.
        is_signed = 1'b0;
        wide = 1'b1;
        dividend = 32'h1234_5678;
        divisor = 16'h1234;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("pre_reset_state_wait", dbg_state, 2'd2);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_quot", quot, 16'h0);
        chk("midrst_rem", rem, 16'h0);
        chk("midrst_err", err, 1'b0);
        m_quot = 16'h0;
        m_rem  = 16'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(1'b0, 1'b0, 32'h0000_0064, 16'h0007, 1'b0);
        chk("post_reset_quot", quot, 16'h000E);
        chk("post_reset_rem", rem, 16'h0002);

        // req held high: one result per acceptance.
        is_signed = 1'b0;
        wide = 1'b1;
        dividend = 32'h0001_0000;
        divisor = 16'h0003;
        req = 1'b1;
        dones = 0;
        for (int i = 0; i < 3 * (DIV_LATENCY + 1); i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        req = 1'b0;
        for (int i = 0; i < DIV_LATENCY + 5; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("held_req_done_count", dones, 3);
        chk("held_req_quot", quot, 16'h5555);
        chk("held_req_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nec_div_ctrl.md
# nec_div_ctrl

Sequencer for the NEC Vxx DIV/DIVU datapath. It accepts a divide request from the microcode engine, builds the sign-extended 33-bit dividend and divisor, and launches the internal `nec_divider`. On completion it checks for divide-by-zero and quotient overflow, including the signed-range cases the divider does not flag. It then returns a registered quotient and remainder for AW/DW (word) or AL/AH (byte) writeback, or raises a divide-error request (INT 0).

## Interface
Parameters: none.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high.
- `ce` in 1: clock enable; all state advances only when high.
- `req` in 1: start request; sampled in IDLE only.
- `is_signed` in 1: 1 = DIV, 0 = DIVU; captured with `req`.
- `wide` in 1: 1 = 32/16 (DW:AW ÷ r16), 0 = 16/8 (AW ÷ r8); captured with `req`.
- `dividend` in 32: word mode uses [31:0]; byte mode uses [15:0].
- `divisor` in 16: word mode uses [15:0]; byte mode uses [7:0].
- `busy` out 1: high from the ce cycle after `req` acceptance through the `done` cycle.
- `done` out 1: one-ce-cycle pulse; result or error valid.
- `err` out 1: divide error (dbz or overflow); valid with `done`.
- `err_dbz` out 1: error cause is a zero divisor; valid with `done`.
- `quot` out 16: quotient; byte mode uses [7:0], with [15:8] = 0.
- `rem` out 16: remainder; byte mode uses [7:0], with [15:8] = 0.

## Operation
- Reset values: `busy`=0, `done`=0, `err`=0, `err_dbz`=0, `quot`=0, `rem`=0, state IDLE.
- The FSM is IDLE → LAUNCH → WAIT → FINISH → IDLE. Every transition requires `ce`.
- **IDLE:** on `req`, capture operands and mode, then go to LAUNCH. A `req` in any other state is ignored.
- **Operand build (at capture):**
  - Word mode: a = {s & dividend[31], dividend}; b = sign/zero-extension of divisor[15:0] to 33 bits.
  - Byte mode: a = {s & dividend[15], ext16(dividend[15:0])}; b = extension of divisor[7:0] to 33 bits.
  - s = `is_signed`; in unsigned mode a[32] = b[32] = 0.
- **LAUNCH:** assert divider `start` for exactly one ce cycle, with `wide` held, then go to WAIT.
- **WAIT:** poll divider `done`, which is a level that the divider clears on the start edge. When it is seen, go to FINISH.
- **FINISH:** register the results, pulse `done`, then go to IDLE. Error precedence is dbz > divider overflow > signed-range overflow.
  - dbz: `err`=`err_dbz`=1.
  - Divider overflow: `err`=1.
  - Signed-range overflow applies when `is_signed` and the divider reports no overflow. Let neg = a[32]^b[32] and q = quotient sign bit (bit 15 word, bit 7 byte). Error when (!neg & q) or (neg & !q & quotient≠0).
  - Net effect: word signed quotient must lie in −32768..+32767; byte signed quotient in −128..+127.
  - On error, `quot`/`rem` hold their previous values.
  - On success, `err`=0 and `quot`/`rem` are updated; byte mode zero-fills [15:8].
- Remainder sign follows the dividend; quotient truncates toward zero. Both are produced by the divider.
- **Reset mid-operation:** `reset` forces IDLE and clears all outputs immediately. The divider shares `reset`. The first `req` after deassertion runs normally.

## Timing
Cycle counts are in ce cycles, with `req` sampled in cycle 0.
- LAUNCH occupies cycle 1.
- Normal path: the divider busies cycles 2–33, its `done` is visible in cycle 34, and FINISH registers it so `done` is high in cycle 35. Latency is 35.
- dbz path: divider `done` is visible in cycle 2, and `done` is high in cycle 3. Latency is 3.
- `busy` is high in cycles 1 through the `done` cycle. A new `req` is accepted in the cycle after `done`.
- With `ce` low, outputs and `done` hold. The `done` pulse spans exactly one ce-enabled cycle.

## Structure
- Package `nec_div_pkg` holds:
  - `div_state_t` enum (IDLE, LAUNCH, WAIT, FINISH);
  - `DIV_LATENCY` = 35;
  - `DIV_DBZ_LATENCY` = 3.
- One sub-module: `nec_divider`, instantiated internally. Its `start`, `wide`, `a` and `b` come from capture registers; `reset` is tied to `reset`.

## Test plan
- **Unsigned word:** DIVU, `dividend`=0x0001_0000, `divisor`=0x0003 → `quot`=0x5555, `rem`=0x0001, `err`=0; `done` 35 cycles after `req`.
- **Signed word:** DIV, 0xFFFF_FFF9 ÷ 0x0002 → `quot`=0xFFFD, `rem`=0xFFFF, `err`=0.
- **Byte:**
  - DIVU 0x0100 ÷ 0x02 → `quot`=0x0080, `rem`=0x0000.
  - DIVU 0x0200 ÷ 0x02 → `err`=1, `err_dbz`=0, `quot`/`rem` unchanged.
- **Signed range:**
  - DIV 0x0000_8000 ÷ 0x0001 → `err`=1.
  - DIV 0xFFFF_8000 ÷ 0x0001 → `quot`=0x8000, `err`=0.
  - Byte DIV 0x0080 ÷ 0x01 → `err`=1.
- **Divide by zero:** `divisor`=0 in both modes → `err`=`err_dbz`=1; `done` 3 cycles after `req`.
- **Control:**
  - `reset` asserted in WAIT cycle 10 → `busy`=`done`=0 immediately; the next `req` (0x64 ÷ 0x07) gives `quot`=0x000E, `rem`=0x0002.
  - `ce` toggled 50% during a run → same results, latency counted in ce cycles.
  - `req` held high while busy → exactly one result per acceptance.
